// File: rtl/tag_rx_io_ctrl.sv
// Receive-side I/O control: 2-entry stream register FIFO, scan-chain clock
// divider, and front-panel GPIO output strobe / input synchronizer.
module tag_rx_io_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned GPIO_REG_WIDTH = 12,
  parameter int unsigned SCAN_DIV_N     = 20,
  parameter int unsigned GPIO_DIV_FAC   = 10,
  parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK = 12'h555,
  parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK  = 12'h000,
  parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR   = 12'h555
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     i_tdata,
  input  logic                      i_tvalid,
  output logic                      i_tready,
  output logic [DATA_WIDTH-1:0]     o_tdata,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic                      clk_div,
  input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] gpio_in,
  input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr
);

  localparam int unsigned HALF   = SCAN_DIV_N / 2;
  localparam int unsigned DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned GPIO_W = (GPIO_DIV_FAC > 1) ? $clog2(GPIO_DIV_FAC) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF - 1);
  localparam logic [GPIO_W-1:0] GPIO_LAST = GPIO_W'(GPIO_DIV_FAC - 1);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  load_head_in, load_head_tail, load_tail;
  logic                  wr, rd;

  assign i_tready = (state != FULL);
  assign o_tvalid = (state != EMPTY);
  assign o_tdata  = head;
  assign wr       = i_tvalid & i_tready;
  assign rd       = o_tvalid & o_tready;

  // head is always the presented beat; tail only holds the second entry
  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail      = 1'b0;
    if (clear) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (wr) begin
            load_head_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          case ({wr, rd})
            2'b11: load_head_in = 1'b1;
            2'b10: begin
              load_tail = 1'b1;
              state_nxt = FULL;
            end
            2'b01: state_nxt = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (rd) begin
            load_head_tail = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head_in)        head <= i_tdata;
      else if (load_head_tail) head <= tail;
      if (load_tail)           tail <= i_tdata;
    end
  end

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      clk_div <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      clk_div <= ~clk_div;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic [GPIO_W-1:0] gpio_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_cnt    <= '0;
      fp_gpio_out <= '0;
    end else if (gpio_cnt == GPIO_LAST) begin
      gpio_cnt    <= '0;
      fp_gpio_out <= gpio_out & OUT_MASK;
    end else begin
      gpio_cnt <= gpio_cnt + 1'b1;
    end
  end

  logic [GPIO_REG_WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= fp_gpio_in;
      sync2 <= sync1;
    end
  end

  assign gpio_in     = sync2 & IN_MASK;
  assign fp_gpio_ddr = IO_DDR;

endmodule

// File: tb/tb_tag_rx_io_ctrl.sv
// Bench for tag_rx_io_ctrl: two instances (default and alternate parameters)
// driven by shared stimulus, checked each cycle against a queue-based model.
module tb_tag_rx_io_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] i_tdata;
  logic        i_tvalid;
  logic        o_tready;
  logic [11:0] gpio_out;
  logic [11:0] fp_gpio_in;

  logic        i_tready_a, o_tvalid_a, clk_div_a;
  logic [31:0] o_tdata_a;
  logic [11:0] gpio_in_a, fp_gpio_out_a, fp_gpio_ddr_a;
  logic        i_tready_b, o_tvalid_b, clk_div_b;
  logic [31:0] o_tdata_b;
  logic [11:0] gpio_in_b, fp_gpio_out_b, fp_gpio_ddr_b;

  always #5 clk = ~clk;

  tag_rx_io_ctrl u_dut_a (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready_a),
    .o_tdata(o_tdata_a), .o_tvalid(o_tvalid_a), .o_tready(o_tready),
    .clk_div(clk_div_a), .gpio_out(gpio_out), .gpio_in(gpio_in_a),
    .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out_a), .fp_gpio_ddr(fp_gpio_ddr_a)
  );

  tag_rx_io_ctrl #(
    .SCAN_DIV_N(4), .GPIO_DIV_FAC(1),
    .OUT_MASK(12'hF0F), .IN_MASK(12'h0FF), .IO_DDR(12'hABC)
  ) u_dut_b (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready_b),
    .o_tdata(o_tdata_b), .o_tvalid(o_tvalid_b), .o_tready(o_tready),
    .clk_div(clk_div_b), .gpio_out(gpio_out), .gpio_in(gpio_in_b),
    .fp_gpio_in(fp_gpio_in), .fp_gpio_out(fp_gpio_out_b), .fp_gpio_ddr(fp_gpio_ddr_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] q[$];
  logic [11:0] hist[$];
  int unsigned n_edges;
  logic [11:0] exp_fp_a, exp_fp_b;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    hist.delete();
    n_edges  = 0;
    exp_fp_a = '0;
    exp_fp_b = '0;
  endtask

  task automatic model_edge();
    bit wr, rd;
    wr = i_tvalid && (q.size() < 2);
    rd = (q.size() > 0) && o_tready;
    if (clear) q.delete();
    else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(i_tdata);
    end
    n_edges++;
    if (n_edges % 10 == 0) exp_fp_a = gpio_out & 12'h555;
    exp_fp_b = gpio_out & 12'hF0F;
    hist.push_back(fp_gpio_in);
    if (hist.size() > 2) void'(hist.pop_front());
  endtask

  task automatic check_all();
    logic        ev;
    logic [11:0] sync_val;
    ev       = (q.size() > 0);
    sync_val = (hist.size() == 2) ? hist[0] : 12'h000;
    check_val("a_tvalid", 32'(o_tvalid_a), 32'(ev));
    check_val("b_tvalid", 32'(o_tvalid_b), 32'(ev));
    check_val("a_tready", 32'(i_tready_a), 32'(q.size() < 2));
    check_val("b_tready", 32'(i_tready_b), 32'(q.size() < 2));
    if (ev) begin
      check_val("a_tdata", o_tdata_a, q[0]);
      check_val("b_tdata", o_tdata_b, q[0]);
    end
    check_val("a_clk_div", 32'(clk_div_a), 32'((n_edges / 10) % 2));
    check_val("b_clk_div", 32'(clk_div_b), 32'((n_edges / 2) % 2));
    check_val("a_fp_out", 32'(fp_gpio_out_a), 32'(exp_fp_a));
    check_val("b_fp_out", 32'(fp_gpio_out_b), 32'(exp_fp_b));
    check_val("a_gpio_in", 32'(gpio_in_a), 32'(sync_val & 12'h000));
    check_val("b_gpio_in", 32'(gpio_in_b), 32'(sync_val & 12'h0FF));
    check_val("a_ddr", 32'(fp_gpio_ddr_a), 32'h555);
    check_val("b_ddr", 32'(fp_gpio_ddr_b), 32'hABC);
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic clr);
    i_tvalid   = v;
    i_tdata    = d;
    o_tready   = rdy;
    clear      = clr;
    gpio_out   = 12'($urandom);
    fp_gpio_in = 12'($urandom);
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_a_tvalid"}, 32'(o_tvalid_a), 32'h0);
    check_val({tag, "_a_tdata"}, o_tdata_a, 32'h0);
    check_val({tag, "_a_tready"}, 32'(i_tready_a), 32'h1);
    check_val({tag, "_a_clk_div"}, 32'(clk_div_a), 32'h0);
    check_val({tag, "_a_fp_out"}, 32'(fp_gpio_out_a), 32'h0);
    check_val({tag, "_a_gpio_in"}, 32'(gpio_in_a), 32'h0);
    check_val({tag, "_a_ddr"}, 32'(fp_gpio_ddr_a), 32'h555);
    check_val({tag, "_b_tvalid"}, 32'(o_tvalid_b), 32'h0);
    check_val({tag, "_b_fp_out"}, 32'(fp_gpio_out_b), 32'h0);
    check_val({tag, "_b_gpio_in"}, 32'(gpio_in_b), 32'h0);
    check_val({tag, "_b_ddr"}, 32'(fp_gpio_ddr_b), 32'hABC);
  endtask

  // Assert reset off-edge, verify immediate effect, hold across an edge, release off-edge.
  task automatic async_reset();
    #($urandom_range(2, 7));
    reset = 1'b1;
    #1 check_reset_values("rst_now");
    model_reset();
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    @(posedge clk);
    #1 check_reset_values("rst_hold");
    #3 reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    i_tdata    = '0;
    i_tvalid   = 1'b0;
    o_tready   = 1'b0;
    gpio_out   = '0;
    fp_gpio_in = 12'hFFF;
    model_reset();
    #12 check_reset_values("rst_init");
    #4 reset = 1'b0;

    // divider/strobe phase from reset, with all-ones GPIO pattern
    for (int unsigned i = 0; i < 25; i++) begin
      i_tvalid   = 1'b0;
      o_tready   = 1'b1;
      clear      = 1'b0;
      gpio_out   = 12'hFFF;
      fp_gpio_in = 12'hFFF;
      @(posedge clk);
      model_edge();
      #1 check_all();
    end

    // back-to-back stream with sink always ready
    for (int unsigned i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // back-pressure: A, B fill the FIFO, C waits until A leaves
    step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
    step(1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
    step(1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // clear while full, with write and read also requested
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    step(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    step(1'b1, 32'h3333_3333, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // random traffic with occasional clears and async resets
    for (int unsigned i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0));
      if (i == 150 || i == 290) async_reset();
    end

    // reset with two beats held: nothing may appear afterwards
    step(1'b1, 32'h4444_4444, 1'b0, 1'b0);
    step(1'b1, 32'h5555_5555, 1'b0, 1'b0);
    async_reset();
    for (int unsigned i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tag_rx_io_ctrl.md
TAG_RX_IO_CTRL -- requirements
Module: tag_rx_io_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the stream path (I in upper half, Q in lower half).
REQ-002 Parameter GPIO_REG_WIDTH, default 12: front-panel GPIO width.
REQ-003 Parameter SCAN_DIV_N, default 20: divided-clock period in clk cycles; even, >=2.
REQ-004 Parameter GPIO_DIV_FAC, default 10: GPIO output update period in clk cycles; >=1.
REQ-005 Parameters OUT_MASK, IN_MASK, IO_DDR, defaults 12'h555, 12'h000, 12'h555: output mask, input mask, and pin direction (1 = output).
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 clear  input  1  synchronous stream flush, active-high.
REQ-009 i_tdata  input  DATA_WIDTH  upstream data.
REQ-010 i_tvalid  input  1  upstream valid.
REQ-011 i_tready  output  1  upstream ready.
REQ-012 o_tdata  output  DATA_WIDTH  downstream data.
REQ-013 o_tvalid  output  1  downstream valid.
REQ-014 o_tready  input  1  downstream ready.
REQ-015 clk_div  output  1  divided clock (scan-chain clock).
REQ-016 gpio_out  input  GPIO_REG_WIDTH  internal value to drive onto the pins.
REQ-017 gpio_in  output  GPIO_REG_WIDTH  synchronized, masked pin inputs.
REQ-018 fp_gpio_in  input  GPIO_REG_WIDTH  raw pin inputs (asynchronous).
REQ-019 fp_gpio_out  output  GPIO_REG_WIDTH  pin output values.
REQ-020 fp_gpio_ddr  output  GPIO_REG_WIDTH  pin direction.

Function
REQ-021 Stream path SHALL be a 2-entry register FIFO: registered o_tdata/o_tvalid, and i_tready = not(both entries full).
REQ-022 A beat SHALL transfer on i_tvalid&i_tready (in) or o_tvalid&o_tready (out); data order SHALL be preserved, with no loss or duplication.
REQ-023 Empty FIFO, write accepted: o_tvalid=1 with that data on the next cycle (1-cycle latency).
REQ-024 Simultaneous read and write SHALL keep occupancy constant; read with no write decrements it; write with no read increments it.
REQ-025 With 2 entries held, i_tready SHALL be 0, and it SHALL return to 1 in the cycle after an output transfer.
REQ-026 clear=1 SHALL empty the FIFO at the next edge (o_tvalid=0, i_tready=1), regardless of i_tvalid/o_tready that cycle.
REQ-027 Divider: counter 0..SCAN_DIV_N/2-1; at the terminal count it wraps to 0 and clk_div toggles, giving period SCAN_DIV_N and 50% duty.
REQ-028 GPIO strobe counter SHALL count 0..GPIO_DIV_FAC-1 and wrap; at count GPIO_DIV_FAC-1, fp_gpio_out <= gpio_out & OUT_MASK; otherwise fp_gpio_out holds.
REQ-029 With GPIO_DIV_FAC=1, fp_gpio_out SHALL update every cycle.
REQ-030 fp_gpio_ddr SHALL equal IO_DDR constantly, including during reset.
REQ-031 gpio_in SHALL be fp_gpio_in passed through a 2-flop synchronizer, then ANDed with IN_MASK (2-cycle latency).
REQ-032 Bits outside OUT_MASK SHALL read 0 on fp_gpio_out; bits outside IN_MASK SHALL read 0 on gpio_in.

Reset
REQ-033 reset SHALL asynchronously force:
- FIFO empty: o_tvalid=0, o_tdata=0, i_tready=1.
- clk_div=0 and divider counter=0.
- GPIO strobe counter=0.
- fp_gpio_out=0, gpio_in=0, synchronizer flops=0.
REQ-034 After reset deasserts, the first clk_div rising edge SHALL occur SCAN_DIV_N/2 edges later, and the first fp_gpio_out update GPIO_DIV_FAC edges later.
REQ-035 Reset asserted mid-transfer SHALL discard all FIFO contents; no beat SHALL be presented after release until a new write.

Verification
REQ-036 Stream stress: o_tready=1, write 0x00000001..0x00000010 back-to-back -> same sequence on o_tdata one cycle later, with i_tready held 1.
REQ-037 Back-pressure: o_tready=0, write A,B,C -> i_tready=0 after B is accepted; then o_tready=1 -> output A then B, then C is accepted.
REQ-038 Clear: hold 2 entries, pulse clear -> o_tvalid=0 and i_tready=1 next cycle; no stale beat afterwards.
REQ-039 Divider: SCAN_DIV_N=20 after reset -> clk_div high for exactly 10 cycles and low for 10, with the first rise at cycle 10.
REQ-040 GPIO: gpio_out=12'hFFF, default masks -> fp_gpio_out=12'h555 after the 10th edge, held between strobes; fp_gpio_ddr=12'h555 always; gpio_in=0 for any fp_gpio_in.
REQ-041 Async reset mid-stream (not aligned to clk) -> immediately o_tvalid=0, clk_div=0, fp_gpio_out=0.
